// File: rtl/max_group_scheduler_if.sv
// Descriptor, beat and datapath-facing signals of max_group_scheduler.
// The master drives the i_* side; the scheduler (slave) drives the o_* side.
interface max_group_scheduler_if #(
    parameter int DATA_W = 1024
);
    logic              i_dp_en;
    logic              i_desc_valid;
    logic              o_desc_ready;
    logic [3:0]        i_desc_mode;
    logic              o_desc_err;
    logic              i_beat_valid;
    logic              o_beat_ready;
    logic [DATA_W-1:0] i_beat_data;
    logic [15:0]       i_beat_locmax;
    logic              o_valid_max;
    logic [15:0]       o_loc_max;
    logic [3:0]        o_length_mode;
    logic [DATA_W-1:0] o_in_flat;
    logic              o_grp_last;
    logic              o_busy;
    logic [15:0]       o_grp_cnt;

    modport master (
        output i_dp_en, i_desc_valid, i_desc_mode, i_beat_valid, i_beat_data, i_beat_locmax,
        input  o_desc_ready, o_desc_err, o_beat_ready, o_valid_max, o_loc_max,
               o_length_mode, o_in_flat, o_grp_last, o_busy, o_grp_cnt
    );

    modport slave (
        input  i_dp_en, i_desc_valid, i_desc_mode, i_beat_valid, i_beat_data, i_beat_locmax,
        output o_desc_ready, o_desc_err, o_beat_ready, o_valid_max, o_loc_max,
               o_length_mode, o_in_flat, o_grp_last, o_busy, o_grp_cnt
    );
endinterface

// File: rtl/max_group_scheduler.sv
// Buffers one whole row group, then issues it unbroken into the max-forwarding
// datapath and tags each group's last beat through the 12-stage pipe.
module max_group_scheduler #(
    parameter int DATA_W    = 1024,
    parameter int MAX_BEATS = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    max_group_scheduler_if.slave   bus
);
    localparam int IDX_W = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE} state_t;

    state_t            state;
    logic [3:0]        mode_q;
    logic [IDX_W-1:0]  n_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              out_last;
    logic [11:0]       tag;

    logic [DATA_W-1:0] data_buf [MAX_BEATS];
    logic [15:0]       lm_buf   [MAX_BEATS];

    function automatic logic [IDX_W-1:0] beats_for(input logic [3:0] m);
        if (m < 4'd3) return IDX_W'(1);
        return IDX_W'(m - 4'd1);
    endfunction

    // Payload storage carries no reset: only slots written in the current FILL are ever read.
    always_ff @(posedge i_clk) begin
        if (state == FILL && bus.i_beat_valid) begin
            data_buf[wr_idx] <= bus.i_beat_data;
            lm_buf[wr_idx]   <= bus.i_beat_locmax;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            mode_q            <= '0;
            n_q               <= '0;
            wr_idx            <= '0;
            rd_idx            <= '0;
            out_last          <= 1'b0;
            tag               <= '0;
            bus.o_desc_ready  <= 1'b1;
            bus.o_beat_ready  <= 1'b0;
            bus.o_desc_err    <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_valid_max   <= 1'b0;
            bus.o_loc_max     <= 16'h8000;
            bus.o_length_mode <= '0;
            bus.o_in_flat     <= '0;
            bus.o_grp_cnt     <= '0;
        end else begin
            bus.o_desc_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_desc_valid) begin
                        if (bus.i_desc_mode >= 4'd14) begin
                            bus.o_desc_err <= 1'b1;
                        end else begin
                            mode_q           <= bus.i_desc_mode;
                            n_q              <= beats_for(bus.i_desc_mode);
                            wr_idx           <= '0;
                            state            <= FILL;
                            bus.o_desc_ready <= 1'b0;
                            bus.o_beat_ready <= 1'b1;
                            bus.o_busy       <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.i_beat_valid) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == n_q - 1'b1) begin
                            state            <= ISSUE;
                            rd_idx           <= '0;
                            bus.o_beat_ready <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.i_dp_en) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == n_q - 1'b1) begin
                            state            <= IDLE;
                            bus.o_desc_ready <= 1'b1;
                            bus.o_busy       <= 1'b0;
                            bus.o_grp_cnt    <= bus.o_grp_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // out_last travels with the registered beat, so tag[11] lines up with
            // the datapath's own output 12 enabled cycles later.
            if (bus.i_dp_en) begin
                if (state == ISSUE) begin
                    bus.o_valid_max   <= 1'b1;
                    bus.o_loc_max     <= lm_buf[rd_idx];
                    bus.o_length_mode <= mode_q;
                    bus.o_in_flat     <= data_buf[rd_idx];
                    out_last          <= (rd_idx == n_q - 1'b1);
                end else begin
                    bus.o_valid_max   <= 1'b0;
                    bus.o_loc_max     <= 16'h8000;
                    bus.o_length_mode <= '0;
                    bus.o_in_flat     <= '0;
                    out_last          <= 1'b0;
                end
                tag <= {tag[10:0], out_last};
            end
        end
    end

    assign bus.o_grp_last = tag[11];
endmodule

// File: tb/tb_max_group_scheduler.sv
// Randomized bench for max_group_scheduler against a transaction-level model:
// an expected-beat queue, an enabled-cycle schedule for o_grp_last and a group counter.
module tb_max_group_scheduler;
    localparam int DATA_W = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    max_group_scheduler_if #(.DATA_W(DATA_W)) bus ();

    max_group_scheduler #(.DATA_W(DATA_W), .MAX_BEATS(12)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0]       lm;
        logic [3:0]        mode;
        logic [DATA_W-1:0] data;
        bit                last;
    } beat_t;

    beat_t       exp_q[$];
    int          pend_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          mon_beats = 0;
    int          gl_pulses = 0;
    int          first_cyc = 0;
    bit          in_group = 1'b0;
    logic [15:0] model_cnt = '0;
    int          force_low = 0;
    bit          dp_rand = 1'b0;

    logic        p_valid, p_gl;
    logic [15:0] p_lm, p_cnt;
    logic [3:0]  p_mode;
    logic [63:0] p_flat_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (force_low > 0) begin
            bus.i_dp_en = 1'b0;
            force_low--;
        end else if (dp_rand) begin
            bus.i_dp_en = ($urandom_range(0, 4) != 0);
        end else begin
            bus.i_dp_en = 1'b1;
        end
    end

    // Output monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        beat_t e;
        bit    exp_gl;
        #1;
        if (rst) begin
            exp_q.delete();
            pend_q.delete();
            model_cnt = '0;
            in_group  = 1'b0;
            check("rst_valid", bus.o_valid_max, 0);
            check("rst_locmax", bus.o_loc_max, 16'h8000);
            check("rst_mode", bus.o_length_mode, 0);
            check("rst_flat", |bus.o_in_flat, 0);
            check("rst_grp_last", bus.o_grp_last, 0);
            check("rst_grp_cnt", bus.o_grp_cnt, 0);
            check("rst_busy", bus.o_busy, 0);
            check("rst_desc_ready", bus.o_desc_ready, 1);
            check("rst_beat_ready", bus.o_beat_ready, 0);
            check("rst_desc_err", bus.o_desc_err, 0);
        end else if (bus.i_dp_en) begin
            en_cnt++;
            exp_gl = (pend_q.size() > 0) && (pend_q[0] == en_cnt);
            if (exp_gl) void'(pend_q.pop_front());
            check("grp_last", bus.o_grp_last, exp_gl);
            if (bus.o_grp_last) gl_pulses++;
            if (bus.o_valid_max) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", bus.o_valid_max, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (!in_group) first_cyc = cyc;
                    check("locmax", bus.o_loc_max, e.lm);
                    check("length_mode", bus.o_length_mode, e.mode);
                    for (int c = 0; c < DATA_W / 64; c++)
                        check("data", bus.o_in_flat[c*64 +: 64], e.data[c*64 +: 64]);
                    mon_beats++;
                    if (e.last) begin
                        in_group  = 1'b0;
                        model_cnt = model_cnt + 16'd1;
                        pend_q.push_back(en_cnt + 12);
                    end else begin
                        in_group = 1'b1;
                    end
                end
            end else begin
                if (in_group) check("contiguous", bus.o_valid_max, 1);
                check("idle_locmax", bus.o_loc_max, 16'h8000);
                check("idle_mode", bus.o_length_mode, 0);
                check("idle_flat", |bus.o_in_flat, 0);
            end
            check("grp_cnt", bus.o_grp_cnt, model_cnt);
        end else begin
            check("hold_valid", bus.o_valid_max, p_valid);
            check("hold_locmax", bus.o_loc_max, p_lm);
            check("hold_mode", bus.o_length_mode, p_mode);
            check("hold_flat", bus.o_in_flat[63:0], p_flat_lo);
            check("hold_grp_last", bus.o_grp_last, p_gl);
            check("hold_grp_cnt", bus.o_grp_cnt, p_cnt);
        end
        p_valid   = bus.o_valid_max;
        p_lm      = bus.o_loc_max;
        p_mode    = bus.o_length_mode;
        p_flat_lo = bus.o_in_flat[63:0];
        p_gl      = bus.o_grp_last;
        p_cnt     = bus.o_grp_cnt;
    end

    // Called at a falling edge; returns at the falling edge after the last accepted beat.
    task automatic send_group(input logic [3:0] mode, input int gap_kind, input bit dir_lm,
                              output int acc_cyc);
        int                n;
        int                budget;
        beat_t             b;
        logic [DATA_W-1:0] d;
        n = (mode <= 2) ? 1 : int'(mode) - 1;
        acc_cyc = cyc;
        budget = 0;
        while (!bus.o_desc_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.o_desc_ready) begin
            check("desc_ready_timeout", bus.o_desc_ready, 1);
            return;
        end
        bus.i_desc_valid = 1'b1;
        bus.i_desc_mode  = mode;
        @(negedge clk);
        bus.i_desc_valid = 1'b0;
        if (mode >= 14) begin
            check("desc_err_pulse", bus.o_desc_err, 1);
            check("err_not_busy", bus.o_busy, 0);
            @(negedge clk);
            check("desc_err_clear", bus.o_desc_err, 0);
            check("err_stays_idle", bus.o_desc_ready, 1);
            acc_cyc = cyc;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if ((gap_kind == 1 && k > 0) || (gap_kind == 2 && $urandom_range(0, 2) == 0)) begin
                bus.i_beat_valid = 1'b0;
                @(negedge clk);
            end
            for (int c = 0; c < DATA_W / 32; c++) d[c*32 +: 32] = $urandom;
            bus.i_beat_data   = d;
            bus.i_beat_locmax = dir_lm ? 16'(5 + 4 * k) : 16'($urandom);
            bus.i_beat_valid  = 1'b1;
            budget = 0;
            while (!bus.o_beat_ready && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (!bus.o_beat_ready) begin
                check("beat_ready_timeout", bus.o_beat_ready, 1);
                bus.i_beat_valid = 1'b0;
                return;
            end
            b.lm   = bus.i_beat_locmax;
            b.mode = mode;
            b.data = d;
            b.last = (k == n - 1);
            exp_q.push_back(b);
            acc_cyc = cyc + 1;
            @(negedge clk);
        end
        bus.i_beat_valid = 1'b0;
    endtask

    task automatic ready_latency(input string tag, input int acc_cyc, input int n);
        int budget = 0;
        while (!bus.o_desc_ready && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        check(tag, cyc - acc_cyc, n);
    endtask

    task automatic wait_done();
        int budget = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !bus.o_desc_ready) && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int acc, b0, g0, budget;
        bus.i_desc_valid  = 1'b0;
        bus.i_desc_mode   = '0;
        bus.i_beat_valid  = 1'b0;
        bus.i_beat_data   = '0;
        bus.i_beat_locmax = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset during ISSUE of a mode-8 group after 3 beats.
        g0 = gl_pulses;
        send_group(4'd8, 0, 1'b0, acc);
        b0 = mon_beats;
        budget = 0;
        while (mon_beats < b0 + 3 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("rst_test_beats", mon_beats - b0, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("after_rst_valid", bus.o_valid_max, 0);
        check("after_rst_busy", bus.o_busy, 0);
        check("after_rst_grp_cnt", bus.o_grp_cnt, 0);
        repeat (20) @(negedge clk);
        check("after_rst_no_grp_last", gl_pulses - g0, 0);
        check("after_rst_no_beats", mon_beats - b0, 3);

        // Mode 3: two beats (locmax 5, 9), back to back.
        g0 = gl_pulses;
        send_group(4'd3, 0, 1'b1, acc);
        ready_latency("m3_ready_latency", acc, 2);
        wait_done();
        check("m3_first_latency", first_cyc - acc, 1);
        repeat (16) @(negedge clk);
        check("m3_grp_last_pulses", gl_pulses - g0, 1);
        check("m3_grp_cnt", bus.o_grp_cnt, 1);

        // Mode 13: twelve beats with beat_valid toggling.
        send_group(4'd13, 1, 1'b0, acc);
        ready_latency("m13_ready_latency", acc, 12);
        wait_done();
        check("m13_first_latency", first_cyc - acc, 1);

        // Mode 6: datapath stalls for 3 cycles after the second issued beat.
        send_group(4'd6, 0, 1'b0, acc);
        b0 = mon_beats;
        budget = 0;
        while (mon_beats < b0 + 2 && budget < 50) begin
            @(posedge clk);
            #2;
            budget++;
        end
        force_low = 3;
        wait_done();
        check("m6_beats", mon_beats - b0, 5);

        // Illegal mode 15, then a single-beat mode-1 group.
        send_group(4'd15, 0, 1'b0, acc);
        send_group(4'd1, 0, 1'b0, acc);
        wait_done();
        check("m1_grp_cnt", bus.o_grp_cnt, 4);

        // Random modes, beat gaps and datapath stalls.
        dp_rand = 1'b1;
        for (int g = 0; g < 25; g++) begin
            send_group(4'($urandom_range(0, 15)), 2, 1'b0, acc);
        end
        wait_done();
        dp_rand = 1'b0;
        repeat (20) @(negedge clk);
        check("end_pending_grp_last", pend_q.size(), 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
